dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter in front of the single `data_memory` port. It shares the memory between the core load/store path (master 0) and a secondary requester such as a boot loader or DMA (master 1). Bursts are round-robin and capped at `MAX_BURST` beats when the other master is waiting. All addressing, including the UART TX MMIO address, passes through unchanged; decoding stays in `data_memory`.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `MAX_BURST`, 4, maximum consecutive beats for one owner while the other master requests; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_req` in 1: master 0 request; held high for all beats of a burst.
- `m0_we` in 1: master 0 write (1) or read (0).
- `m0_addr` in XLEN: master 0 byte address.
- `m0_wdata` in XLEN: master 0 store data.
- `m0_size` in 3: master 0 funct3 size code (0/1/2/4/5).
- `m0_gnt` out 1: master 0 owns the port; every cycle with `m0_req & m0_gnt` is one beat.
- `m0_rdata` out XLEN: master 0 load data, valid during a read beat.
- `m0_rvalid` out 1: `m0_gnt & m0_req & ~m0_we`.
- `m1_*`: identical set for master 1.
- `mem_address` out XLEN: to `data_memory` address.
- `mem_data_in` out XLEN: to `data_memory` data_in.
- `mem_write_enable` out 1: to `data_memory` write_enable.
- `mem_word_size` out 3: to `data_memory` word_size.
- `mem_data_out` in XLEN: from `data_memory` data_out (combinational read).

## Operation
- States: IDLE, OWN0, OWN1 (registered). `mX_gnt` = state==OWNX.
- Round-robin pointer `last` (registered): the master most recently granted.
- Burst counter `beats` (registered, width clog2(MAX_BURST)+1): counts beats in the current ownership.
- IDLE:
  - One request pending → go to that master's OWN state.
  - Both pending → grant the master ≠ `last`.
  - None pending → stay in IDLE.
  - On entering an OWN state: `beats`=0, `last`=new owner.
- OWNx, each cycle:
  - Beat (`mx_req`=1) → `beats`+1.
  - Release condition: `mx_req`=0, OR (`beats`+1 == MAX_BURST AND other req=1).
  - On release: other req=1 → go directly to OWN(other) with `beats`=0, `last`=other. Otherwise → IDLE.
  - `beats` reaching MAX_BURST with no contender → stay, counter saturates, no release.
- Mux: the memory outputs carry the owner's addr/wdata/size.
  - `mem_write_enable` = owner_req & owner_we & ~rst.
  - In IDLE all mem outputs are 0.
- `mx_rdata` = `mem_data_out` when `mx_gnt`, else 0.
- Deasserting `req` mid-burst is legal. The cycle with req=0 is not a beat and releases ownership.
- Requests with `gnt`=0 are ignored. Masters must hold addr/we/wdata/size stable until `gnt`.

## Timing
- Grant latency: req rises in cycle N while in IDLE → `gnt` high in N+1. First beat in N+1; a write commits at the end of N+1.
- Handover: contended release at edge E → other master's `gnt` in the cycle after E, zero idle cycles. Old `gnt` low in the same cycle.
- Read beat: data is combinational, same cycle as the beat (memory read is async).
- Reset values: state IDLE; `last`=1, so master 0 wins the first tie; `beats`=0.
  - Reset outputs: all `gnt`/`rvalid`=0, `rdata`=0, all `mem_*` outputs=0.
- Reset mid-burst: the asserted cycle performs no write (`~rst` gating). `gnt` is low the cycle after reset is sampled.
- Simultaneous release of owner and new req from other: handover as above. Both req low → IDLE.

## Test plan
- Reset, then m0 read: m0_req=1, addr=0x10, size=2 → m0_gnt=1 one cycle later. m0_rvalid=1 with m0_rdata = word at 0x10. mem_write_enable=0.
- Tie after reset: m0 and m1 req together with MAX_BURST=4, both held → m0 gets 4 beats, then m1 gets 4 beats, then m0. No idle cycle at either switch.
- Uncontended long burst: m1 writes 6 bytes 0x20..0x25, size=0, m0 idle → m1_gnt stays high all 6 beats. Readback shows all 6 bytes.
- Early release: m0 owns with 1 beat done, m0_req drops, m1_req=1 → m1_gnt next cycle. m0 gets no further beats.
- Reset mid-write: m1 writing 0xDEADBEEF to 0x40 with rst=1 that cycle → mem_write_enable=0. Word at 0x40 unchanged. All gnt=0 next cycle.
- MMIO passthrough: m0 writes 0x41 to 0x680 → mem_address=0x680 and mem_write_enable=1 for exactly one cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of the single data_memory port.
// Bursts are capped at MAX_BURST beats only while the other master is waiting.
module dmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [2:0]      m0_size,
  output logic            m0_gnt,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_rvalid,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [2:0]      m1_size,
  output logic            m1_gnt,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_data_in,
  output logic            mem_write_enable,
  output logic [2:0]      mem_word_size,
  input  logic [XLEN-1:0] mem_data_out
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW:0] CAP = (BW+1)'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] beats, beats_nxt;
  logic [BW:0]   beats_inc;
  logic          own_req, oth_req, own_we;

  assign own_req   = (state == OWN0 && m0_req) || (state == OWN1 && m1_req);
  assign oth_req   = (state == OWN0) ? m1_req : m0_req;
  // One bit wider than beats so the saturated value can still be incremented.
  assign beats_inc = {1'b0, beats} + (BW+1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      beats <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      beats <= beats_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    beats_nxt = beats;
    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || last)) begin
          state_nxt = OWN0;
          last_nxt  = 1'b0;
          beats_nxt = '0;
        end else if (m1_req) begin
          state_nxt = OWN1;
          last_nxt  = 1'b1;
          beats_nxt = '0;
        end
      end
      OWN0, OWN1: begin
        // >= rather than == so a contender arriving after saturation still wins.
        if (!own_req || (beats_inc >= CAP && oth_req)) begin
          beats_nxt = '0;
          if (oth_req) begin
            state_nxt = (state == OWN0) ? OWN1 : OWN0;
            last_nxt  = (state == OWN0);
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          beats_nxt = (beats_inc >= CAP) ? CAP[BW-1:0] : beats_inc[BW-1:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_address   = '0;
    mem_data_in   = '0;
    mem_word_size = '0;
    own_we        = 1'b0;
    case (state)
      OWN0: begin
        mem_address   = m0_addr;
        mem_data_in   = m0_wdata;
        mem_word_size = m0_size;
        own_we        = m0_we;
      end
      OWN1: begin
        mem_address   = m1_addr;
        mem_data_in   = m1_wdata;
        mem_word_size = m1_size;
        own_we        = m1_we;
      end
      default: ;
    endcase
  end

  // rst gating keeps a beat in the reset cycle from committing a store.
  assign mem_write_enable = own_req & own_we & ~rst;

  assign m0_gnt    = (state == OWN0);
  assign m1_gnt    = (state == OWN1);
  assign m0_rvalid = m0_gnt & m0_req & ~m0_we;
  assign m1_rvalid = m1_gnt & m1_req & ~m1_we;
  assign m0_rdata  = m0_gnt ? mem_data_out : '0;
  assign m1_rdata  = m1_gnt ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against
// an ownership/beat-count reference model and a byte-level memory image.
module tb_dmem_arbiter;
  localparam int XLEN = 32;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [2:0] m0_size;
  logic m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [2:0] m1_size;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic mem_write_enable;
  logic [2:0] mem_word_size;

  logic [7:0] mem [0:4095];
  logic [11:0] ma;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(XLEN), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_write_enable(mem_write_enable),
    .mem_word_size(mem_word_size), .mem_data_out(mem_data_out)
  );

  function automatic logic [31:0] ld(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3,
                                     input logic [2:0] size);
    case (size)
      3'd0:    ld = {{24{b0[7]}}, b0};
      3'd1:    ld = {{16{b1[7]}}, b1, b0};
      3'd4:    ld = {24'd0, b0};
      3'd5:    ld = {16'd0, b1, b0};
      default: ld = {b3, b2, b1, b0};
    endcase
  endfunction

  // Simple data_memory stand-in: async read, write at the clock edge.
  assign ma = mem_address[11:0];
  assign mem_data_out = ld(mem[ma], mem[ma + 12'd1], mem[ma + 12'd2], mem[ma + 12'd3], mem_word_size);

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[ma] <= mem_data_in[7:0];
      if (mem_word_size[1:0] != 2'd0) mem[ma + 12'd1] <= mem_data_in[15:8];
      if (mem_word_size[1:0] == 2'd2) begin
        mem[ma + 12'd2] <= mem_data_in[23:16];
        mem[ma + 12'd3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_size = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_size = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h44; m0_wdata = 32'h55; m0_size = 3'd2;
    m1_req = 1; m1_we = 1; m1_addr = 32'h48; m1_wdata = 32'h66; m1_size = 3'd2;
    cyc; cyc;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt got %b want 0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt got %b want 0", m1_gnt); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {m0_rvalid, m1_rvalid}); end
    checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0", m0_rdata, m1_rdata); end
    checks++; if (mem_address !== 32'd0 || mem_data_in !== 32'd0) begin errors++; $display("FAIL rst_mem_bus got %h/%h want 0", mem_address, mem_data_in); end
    checks++; if (mem_write_enable !== 1'b0 || mem_word_size !== 3'd0) begin errors++; $display("FAIL rst_mem_ctl got %b/%0d want 0", mem_write_enable, mem_word_size); end
    idle_in; rst = 0;
    cyc;
  endtask

  task automatic test_read;
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h12345678; m0_size = 3'd2;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL read_gnt_latency got %b want 0", m0_gnt); end
    cyc;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL read_gnt got %b want 1", m0_gnt); end
    checks++; if (mem_write_enable !== 1'b1 || mem_address !== 32'h10) begin errors++; $display("FAIL read_prewrite got we=%b addr=%h want 1/10", mem_write_enable, mem_address); end
    cyc;
    m0_we = 0;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL read_rvalid got %b want 1", m0_rvalid); end
    checks++; if (m0_rdata !== 32'h12345678) begin errors++; $display("FAIL read_rdata got %h want 12345678", m0_rdata); end
    checks++; if (mem_write_enable !== 1'b0 || m1_rdata !== 32'd0) begin errors++; $display("FAIL read_we got we=%b m1_rdata=%h want 0/0", mem_write_enable, m1_rdata); end
    m0_req = 0;
    cyc;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0 || mem_address !== 32'd0) begin errors++; $display("FAIL read_release got gnt=%b addr=%h want 0/0", m0_gnt, mem_address); end
    idle_in;
  endtask

  task automatic test_tie;
    logic e0, e1;
    rst = 1; idle_in; cyc; rst = 0;
    m0_req = 1; m0_addr = 32'h10; m0_size = 3'd2;
    m1_req = 1; m1_addr = 32'h10; m1_size = 3'd2;
    for (int c = 0; c < 11; c++) begin
      e0 = (c > 0) && (((c - 1) / MAX_BURST) % 2 == 0);
      e1 = (c > 0) && !e0;
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== {e0, e1}) begin errors++; $display("FAIL tie_gnt c=%0d got %b%b want %b%b", c, m0_gnt, m1_gnt, e0, e1); end
      if (e1) begin
        checks++; if (m1_rdata !== 32'h12345678 || m0_rdata !== 32'd0) begin errors++; $display("FAIL tie_rdata c=%0d got %h/%h want 0/12345678", c, m0_rdata, m1_rdata); end
      end
      cyc;
    end
    idle_in; cyc; cyc;
  endtask

  task automatic test_long_burst;
    m1_req = 1; m1_we = 1; m1_size = 3'd0; m1_addr = 32'h20; m1_wdata = 32'hA0;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL burst_pre_gnt got %b want 0", m1_gnt); end
    cyc;
    for (int i = 0; i < 6; i++) begin
      m1_addr = 32'h20 + i; m1_wdata = 32'hA0 + i;
      @(negedge clk);
      checks++; if (m1_gnt !== 1'b1 || mem_write_enable !== 1'b1) begin errors++; $display("FAIL burst_gnt i=%0d got gnt=%b we=%b want 1/1", i, m1_gnt, mem_write_enable); end
      checks++; if (mem_address !== 32'h20 + i || mem_data_in !== 32'hA0 + i) begin errors++; $display("FAIL burst_bus i=%0d got %h/%h", i, mem_address, mem_data_in); end
      cyc;
    end
    m1_req = 0; m1_we = 0;
    m0_req = 1; m0_we = 0; m0_size = 3'd4; m0_addr = 32'h20;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt, mem_write_enable} !== 3'b010) begin errors++; $display("FAIL burst_release got %b%b%b want 010", m0_gnt, m1_gnt, mem_write_enable); end
    cyc;
    for (int i = 0; i < 6; i++) begin
      m0_addr = 32'h20 + i;
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b1 || m0_rdata !== 32'hA0 + i) begin errors++; $display("FAIL burst_readback i=%0d got gnt=%b data=%h want 1/%h", i, m0_gnt, m0_rdata, 32'hA0 + i); end
      cyc;
    end
    idle_in; cyc;
  endtask

  task automatic test_early_release;
    m0_req = 1; m0_addr = 32'h10; m0_size = 3'd2;
    cyc;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL early_first_beat got %b want 1", m0_gnt); end
    cyc;
    m0_req = 0; m1_req = 1; m1_addr = 32'h10; m1_size = 3'd2;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0 || m1_gnt !== 1'b0) begin errors++; $display("FAIL early_drop got rvalid=%b m1_gnt=%b want 0/0", m0_rvalid, m1_gnt); end
    cyc;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL early_handover got %b%b want 01", m0_gnt, m1_gnt); end
    checks++; if (m1_rdata !== 32'h12345678) begin errors++; $display("FAIL early_rdata got %h want 12345678", m1_rdata); end
    idle_in; cyc; cyc;
  endtask

  task automatic test_reset_mid_write;
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h11223344; m1_size = 3'd2;
    cyc;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || mem_write_enable !== 1'b1) begin errors++; $display("FAIL rmw_first got gnt=%b we=%b want 1/1", m1_gnt, mem_write_enable); end
    cyc;
    m1_wdata = 32'hDEADBEEF; rst = 1;
    @(negedge clk);
    checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL rmw_we_gated got %b want 0", mem_write_enable); end
    cyc;
    rst = 0; m1_req = 0; m1_we = 0;
    @(negedge clk);
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL rmw_gnt_after got %b%b want 00", m0_gnt, m1_gnt); end
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; m0_size = 3'd2;
    cyc;
    @(negedge clk);
    checks++; if (m0_rdata !== 32'h11223344) begin errors++; $display("FAIL rmw_unchanged got %h want 11223344", m0_rdata); end
    idle_in; cyc; cyc;
  endtask

  task automatic test_mmio;
    int pulses;
    pulses = 0;
    m0_req = 1; m0_we = 1; m0_addr = 32'h680; m0_wdata = 32'h41; m0_size = 3'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_write_enable === 1'b1) begin
        pulses++;
        checks++; if (mem_address !== 32'h680 || mem_data_in !== 32'h41) begin errors++; $display("FAIL mmio_bus got %h/%h want 680/41", mem_address, mem_data_in); end
      end
      cyc;
      if (c == 1) m0_req = 0;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL mmio_pulses got %0d want 1", pulses); end
    m0_req = 1; m0_we = 0; m0_size = 3'd4;
    cyc;
    @(negedge clk);
    checks++; if (m0_rdata !== 32'h41) begin errors++; $display("FAIL mmio_readback got %h want 41", m0_rdata); end
    idle_in; cyc; cyc;
  endtask

  // Reference model state for the randomized run.
  int own, lastm, done, prev_own, eoff, nb, off;
  logic kn;
  logic r_rst;
  logic rq [2];
  logic rw [2];
  logic [31:0] ra [2];
  logic [31:0] rdt [2];
  logic [2:0] rs [2];
  logic [7:0] refm [64];
  logic known [64];
  logic [2:0] szl [5];
  logic [31:0] exp_rd;

  task automatic test_random;
    szl[0] = 3'd0; szl[1] = 3'd1; szl[2] = 3'd2; szl[3] = 3'd4; szl[4] = 3'd5;
    for (int k = 0; k < 64; k++) begin known[k] = 0; refm[k] = 8'd0; end
    for (int i = 0; i < 2; i++) begin rq[i] = 0; rw[i] = 0; ra[i] = 32'h100; rdt[i] = 0; rs[i] = 0; end
    rst = 1; idle_in; cyc; rst = 0;
    own = -1; lastm = 1; done = 0;
    for (int cy = 0; cy < 600; cy++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!(rq[i] && own != i)) begin
          rq[i] = ($urandom_range(0, 9) < 6);
          rw[i] = $urandom_range(0, 1) == 1;
          rs[i] = rw[i] ? szl[$urandom_range(0, 2)] : szl[$urandom_range(0, 4)];
          off = $urandom_range(0, 63);
          if (rs[i][1:0] == 2'd1) off = off & ~1;
          if (rs[i][1:0] == 2'd2) off = off & ~3;
          ra[i] = 32'h100 + off;
          rdt[i] = $urandom;
        end
      end
      rst = r_rst;
      m0_req = rq[0]; m0_we = rw[0]; m0_addr = ra[0]; m0_wdata = rdt[0]; m0_size = rs[0];
      m1_req = rq[1]; m1_we = rw[1]; m1_addr = ra[1]; m1_wdata = rdt[1]; m1_size = rs[1];
      @(negedge clk);
      checks++; if ({m0_gnt, m1_gnt} !== {own == 0, own == 1}) begin errors++; $display("FAIL rnd_gnt cy=%0d got %b%b want owner %0d", cy, m0_gnt, m1_gnt, own); end
      checks++; if (mem_write_enable !== (own >= 0 && rq[own] && rw[own] && !r_rst)) begin errors++; $display("FAIL rnd_we cy=%0d got %b owner %0d", cy, mem_write_enable, own); end
      checks++; if (mem_address !== (own < 0 ? 32'd0 : ra[own]) || mem_word_size !== (own < 0 ? 3'd0 : rs[own])) begin errors++; $display("FAIL rnd_addr cy=%0d got %h/%0d owner %0d", cy, mem_address, mem_word_size, own); end
      checks++; if (mem_data_in !== (own < 0 ? 32'd0 : rdt[own])) begin errors++; $display("FAIL rnd_wdata cy=%0d got %h owner %0d", cy, mem_data_in, own); end
      checks++; if ({m0_rvalid, m1_rvalid} !== {own == 0 && rq[0] && !rw[0], own == 1 && rq[1] && !rw[1]}) begin errors++; $display("FAIL rnd_rvalid cy=%0d got %b%b owner %0d", cy, m0_rvalid, m1_rvalid, own); end
      for (int i = 0; i < 2; i++) begin
        if (own == i) begin
          eoff = int'(ra[i]) - 32'h100;
          nb = (rs[i][1:0] == 2'd0) ? 1 : (rs[i][1:0] == 2'd1) ? 2 : 4;
          kn = 1;
          for (int k = 0; k < nb; k++) if (!known[(eoff + k) & 63]) kn = 0;
          if (kn) begin
            exp_rd = ld(refm[eoff], refm[(eoff + 1) & 63], refm[(eoff + 2) & 63], refm[(eoff + 3) & 63], rs[i]);
            checks++; if ((i == 0 ? m0_rdata : m1_rdata) !== exp_rd) begin errors++; $display("FAIL rnd_rdata cy=%0d m%0d got %h want %h", cy, i, (i == 0 ? m0_rdata : m1_rdata), exp_rd); end
          end
        end else begin
          checks++; if ((i == 0 ? m0_rdata : m1_rdata) !== 32'd0) begin errors++; $display("FAIL rnd_rdata_idle cy=%0d m%0d got %h want 0", cy, i, (i == 0 ? m0_rdata : m1_rdata)); end
        end
      end
      // Commit the owner's store into the reference image, then advance ownership.
      if (!r_rst && own >= 0 && rq[own] && rw[own]) begin
        eoff = int'(ra[own]) - 32'h100;
        nb = (rs[own][1:0] == 2'd0) ? 1 : (rs[own][1:0] == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) begin
          refm[eoff + k] = rdt[own][8*k +: 8];
          known[eoff + k] = 1;
        end
      end
      prev_own = own;
      if (r_rst) begin
        own = -1; lastm = 1; done = 0;
      end else if (own < 0) begin
        if (rq[0] && rq[1]) own = 1 - lastm;
        else if (rq[0]) own = 0;
        else if (rq[1]) own = 1;
        if (own >= 0) begin lastm = own; done = 0; end
      end else begin
        if (!rq[own]) own = rq[1 - own] ? 1 - own : -1;
        else begin
          done++;
          if (rq[1 - own] && done >= MAX_BURST) own = 1 - own;
        end
        if (own != prev_own) begin done = 0; if (own >= 0) lastm = own; end
      end
      cyc;
    end
    rst = 0; idle_in; cyc; cyc;
  endtask

  initial begin
    rst = 1;
    idle_in;
    test_reset;
    test_read;
    test_tie;
    test_long_burst;
    test_early_release;
    test_reset_mid_write;
    test_mmio;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
